// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between a fetch and a data requester,
// with registered transfer attributes and a per-transfer timeout abort.
module mem_port_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] addr0,
  output logic        ack0,
  output logic        err0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic        we1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rdata1,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        sel
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q, state_d;
  logic        sel_q, sel_d, last_q, last_d, we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        grant, busy, tmo, live;
  assign busy  = (state_q == BUSY);
  // Contention goes to whoever was not served last; otherwise the sole requester.
  assign grant = (req0 & req1) ? ~last_q : req1;
  assign tmo   = busy & ~mem_ack & (cnt_q == 8'(TIMEOUT - 1));
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    if (!busy && (req0 || req1)) begin
      state_d = BUSY;
      sel_d   = grant;
      cnt_d   = '0;
      addr_d  = grant ? addr1 : addr0;
      wdata_d = grant ? wdata1 : '0;
      we_d    = grant & we1;
    end else if (busy && (mem_ack || tmo)) begin
      state_d = IDLE;
      last_d  = sel_q;
      cnt_d   = '0;
    end else if (busy) begin
      cnt_d = cnt_q + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end
  // Reset suppresses every handshake output, even a coincident mem_ack.
  assign live      = busy & ~reset;
  assign mem_req   = live;
  assign ack0      = live & mem_ack & ~sel_q;
  assign ack1      = live & mem_ack & sel_q;
  assign err0      = live & tmo & ~sel_q;
  assign err1      = live & tmo & sel_q;
  assign rdata0    = ack0 ? mem_rdata : '0;
  assign rdata1    = ack1 ? mem_rdata : '0;
  assign sel       = sel_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int TO = 15;
  logic        clk = 0, reset = 1;
  logic        req0 = 0, req1 = 0, we1 = 0, mem_ack = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata1 = 0, mem_rdata = 0;
  logic        ack0, err0, ack1, err1, mem_req, mem_we, sel;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  int checks = 0, errors = 0;
  // Model: is a transfer outstanding, who owns it, who was served last, how long it has waited.
  bit          m_busy = 0, m_sel = 0, m_last = 1, m_we = 0;
  int          m_wait = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic        s_ack0, s_ack1, s_err0, s_err1, s_req, s_sel, s_we;
  logic [31:0] s_rd0, s_rd1, s_addr, s_wdata;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req0(req0), .addr0(addr0), .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .sel(sel));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    bit done_ack, done_err, g;
    @(negedge clk);
    done_ack = m_busy && !reset && mem_ack;
    done_err = m_busy && !reset && !mem_ack && (m_wait + 1 == TO);
    chk("mem_req", mem_req, m_busy && !reset);
    chk("sel", sel, m_sel);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_we", mem_we, m_we);
    chk("ack0", ack0, done_ack && !m_sel);
    chk("ack1", ack1, done_ack && m_sel);
    chk("err0", err0, done_err && !m_sel);
    chk("err1", err1, done_err && m_sel);
    chk("rdata0", rdata0, (done_ack && !m_sel) ? mem_rdata : 32'd0);
    chk("rdata1", rdata1, (done_ack && m_sel) ? mem_rdata : 32'd0);
    {s_ack0, s_ack1, s_err0, s_err1, s_req, s_sel, s_we} = {ack0, ack1, err0, err1, mem_req, sel, mem_we};
    {s_rd0, s_rd1, s_addr, s_wdata} = {rdata0, rdata1, mem_addr, mem_wdata};
    @(posedge clk);
    if (reset) begin
      {m_busy, m_sel, m_last, m_we, m_wait, m_addr, m_wdata} = {1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0};
    end else if (!m_busy) begin
      if (req0 || req1) begin
        g = (req0 && req1) ? !m_last : req1;
        m_busy = 1; m_sel = g; m_wait = 0;
        m_addr = g ? addr1 : addr0;
        m_wdata = g ? wdata1 : 32'd0;
        m_we = g && we1;
      end
    end else if (done_ack || done_err) begin
      m_busy = 0; m_last = m_sel;
    end else m_wait++;
    #1;
  endtask

  initial begin
    int hold;
    step(); step();
    reset = 0;
    step();
    chk("rst_mem_req", s_req, 1'b0);
    chk("rst_sel", s_sel, 1'b0);
    chk("rst_addr", s_addr, 32'd0);
    // Fetch read
    req0 = 1; addr0 = 32'h0040_0000;
    step();
    mem_ack = 1; mem_rdata = 32'h8C08_0004;
    step();
    chk("f_ack0", s_ack0, 1'b1);
    chk("f_rdata0", s_rd0, 32'h8C08_0004);
    chk("f_addr", s_addr, 32'h0040_0000);
    chk("f_we", s_we, 1'b0);
    req0 = 0; mem_ack = 0;
    step();
    // Data write
    req1 = 1; we1 = 1; addr1 = 32'h1001_0000; wdata1 = 32'hDEAD_BEEF;
    step();
    mem_ack = 1;
    step();
    chk("w_ack1", s_ack1, 1'b1);
    chk("w_ack0", s_ack0, 1'b0);
    chk("w_sel", s_sel, 1'b1);
    chk("w_we", s_we, 1'b1);
    chk("w_wdata", s_wdata, 32'hDEAD_BEEF);
    req1 = 0; we1 = 0; mem_ack = 0;
    // Alternation from reset with both held
    reset = 1; step(); reset = 0;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      mem_ack = 1; step(); mem_ack = 0;
      chk("rr_owner", s_sel, 32'(i % 2));
      chk("rr_ack", i % 2 ? s_ack1 : s_ack0, 1'b1);
    end
    req0 = 0; req1 = 0;
    step();
    // Timeout, then ack coinciding with the timeout cycle
    req1 = 1;
    step();
    for (int k = 1; k <= TO; k++) begin
      step();
      if (k == TO - 1) chk("to_early", s_err1, 1'b0);
    end
    chk("to_err1", s_err1, 1'b1);
    req1 = 0;
    step();
    chk("to_idle", s_req, 1'b0);
    req1 = 1;
    step();
    for (int k = 1; k < TO; k++) step();
    mem_ack = 1; step(); mem_ack = 0; req1 = 0;
    chk("tie_ack1", s_ack1, 1'b1);
    chk("tie_err1", s_err1, 1'b0);
    // Reset in third busy cycle with coincident mem_ack
    req0 = 1; req1 = 1;
    step(); step(); step();
    reset = 1; mem_ack = 1; step();
    chk("rb_ack", {s_ack0, s_ack1}, 2'b00);
    chk("rb_req", s_req, 1'b0);
    reset = 0; mem_ack = 0; req0 = 0; req1 = 0;
    step();
    chk("rb_req_next", s_req, 1'b0);
    chk("rb_sel_next", s_sel, 1'b0);
    // Stray ack while idle
    mem_ack = 1; step();
    chk("stray", {s_ack0, s_ack1, s_err0, s_err1, s_req}, 5'b0);
    mem_ack = 0;
    // Random traffic; ack probability changes in phases to exercise timeouts
    hold = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) hold = (($urandom % 3) == 0) ? 3 : 50;
      if (s_ack0 || s_err0 || ($urandom % 40 == 0)) req0 = 0;
      else if (!req0 && ($urandom % 3 == 0)) begin req0 = 1; addr0 = $urandom; end
      if (s_ack1 || s_err1 || ($urandom % 40 == 0)) req1 = 0;
      else if (!req1 && ($urandom % 3 == 0)) begin
        req1 = 1; addr1 = $urandom; wdata1 = $urandom; we1 = $urandom % 2;
      end
      mem_ack = ($urandom % 100) < hold;
      mem_rdata = $urandom;
      reset = ($urandom % 300 == 0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
